// File: rtl/dwc_pkg.sv
// Shared types and helpers for the DWC mismatch handler: FSM states, the
// default mismatch polarity, and the flag-to-mismatch decode.
package dwc_pkg;

   typedef enum logic [1:0] {
      MONITOR = 2'd0,
      RETRY   = 2'd1,
      WAIT    = 2'd2,
      FAULT   = 2'd3
   } dwc_state_e;

   // The DWC detector is an XNOR, so a low flag means the copies disagree.
   localparam logic DWC_MISMATCH_LEVEL = 1'b0;

   function automatic logic isMismatch(input logic flag, input logic valid, input logic level);
      return valid && (flag == level);
   endfunction

endpackage

// File: rtl/dwc_retry_timer.sv
// Loadable down-counter with a zero flag; paces flag re-evaluation after a
// retry pulse.
module dwc_retry_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] loadValue_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = loadValue_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/dwc_error_handler.sv
// Classifies DWC mismatches as transient or permanent by holding the datapath
// and requesting bounded re-execution before raising a sticky fault.
module dwc_error_handler
   import dwc_pkg::*;
#(
   parameter int   N              = 4,
   parameter logic MISMATCH_LEVEL = DWC_MISMATCH_LEVEL,
   parameter int   MAX_RETRY      = 2,
   parameter int   RETRY_WAIT     = 4,
   parameter int   CNT_W          = 8
) (
   input  logic             port_clk,
   input  logic             port_rst_n,
   input  logic             port_valid,
   input  logic [N-1:0]     port_dwc_error,
   input  logic             port_clear,
   output logic             port_retry,
   output logic             port_hold,
   output logic [N-1:0]     port_syndrome,
   output logic [CNT_W-1:0] port_transient_cnt,
   output logic             port_fault
);

   localparam int TIMER_W = $clog2(RETRY_WAIT + 1);
   localparam int RC_W    = $clog2(MAX_RETRY + 1);

   dwc_state_e       state_q, state_d;
   logic [RC_W-1:0]  retryCnt_q, retryCnt_d;
   logic [N-1:0]     syndrome_q, syndrome_d;
   logic [CNT_W-1:0] transientCnt_q, transientCnt_d;

   logic [N-1:0]     mismatch;
   logic             anyMismatch;
   logic [N-1:0]     syndromeBase;
   logic [CNT_W-1:0] transientBase;
   logic             timerLoad;
   logic             timerDec;
   logic             timerZero;

   always_comb begin
      mismatch = '0;
      for (int i = 0; i < N; i++) begin
         mismatch[i] = isMismatch(port_dwc_error[i], port_valid, MISMATCH_LEVEL);
      end
   end

   assign anyMismatch = |mismatch;

   dwc_retry_timer #(
      .WIDTH (TIMER_W)
   ) u_retry_timer (
      .clk_i       (port_clk),
      .rst_ni      (port_rst_n),
      .load_i      (timerLoad),
      .loadValue_i (TIMER_W'(RETRY_WAIT)),
      .dec_i       (timerDec),
      .zero_o      (timerZero)
   );

   // A clear is applied to the history registers first, so any mismatch bits
   // or recovery counted in the same cycle land on top of the cleared value.
   always_comb begin
      syndromeBase   = port_clear ? '0 : syndrome_q;
      transientBase  = port_clear ? '0 : transientCnt_q;
      state_d        = state_q;
      retryCnt_d     = retryCnt_q;
      syndrome_d     = syndromeBase;
      transientCnt_d = transientBase;
      timerLoad      = 1'b0;
      timerDec       = 1'b0;

      case (state_q)
         MONITOR: begin
            if (anyMismatch) begin
               syndrome_d = syndromeBase | mismatch;
               retryCnt_d = RC_W'(1);
               state_d    = RETRY;
            end
         end
         RETRY: begin
            timerLoad = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            if (!timerZero) begin
               timerDec = 1'b1;
            end else if (port_valid) begin
               if (anyMismatch) begin
                  syndrome_d = syndromeBase | mismatch;
                  if (retryCnt_q == RC_W'(MAX_RETRY)) begin
                     state_d = FAULT;
                  end else begin
                     retryCnt_d = retryCnt_q + RC_W'(1);
                     state_d    = RETRY;
                  end
               end else begin
                  transientCnt_d = (&transientBase) ? transientBase : transientBase + CNT_W'(1);
                  retryCnt_d     = '0;
                  state_d        = MONITOR;
               end
            end
         end
         FAULT: begin
            if (port_clear) begin
               retryCnt_d = '0;
               state_d    = MONITOR;
            end
         end
         default: begin
            state_d = MONITOR;
         end
      endcase
   end

   always_ff @(posedge port_clk or negedge port_rst_n) begin
      if (!port_rst_n) begin
         state_q        <= MONITOR;
         retryCnt_q     <= '0;
         syndrome_q     <= '0;
         transientCnt_q <= '0;
      end else begin
         state_q        <= state_d;
         retryCnt_q     <= retryCnt_d;
         syndrome_q     <= syndrome_d;
         transientCnt_q <= transientCnt_d;
      end
   end

   assign port_retry         = (state_q == RETRY);
   assign port_hold          = (state_q != MONITOR);
   assign port_fault         = (state_q == FAULT);
   assign port_syndrome      = syndrome_q;
   assign port_transient_cnt = transientCnt_q;

endmodule

// File: tb/tb_dwc_error_handler.sv
// Directed scoreboard bench for dwc_error_handler: a default instance and a
// 2-bit-counter instance share stimulus so counter saturation is visible.
module tb_dwc_error_handler;

   logic       port_clk = 1'b0;
   logic       port_rst_n;
   logic       port_valid;
   logic [3:0] port_dwc_error;
   logic       port_clear;

   logic       port_retry,  satRetry;
   logic       port_hold,   satHold;
   logic [3:0] port_syndrome, satSyndrome;
   logic [7:0] port_transient_cnt;
   logic [1:0] satTransientCnt;
   logic       port_fault,  satFault;

   typedef struct {
      string       tag;
      logic [14:0] expMain;
      logic [8:0]  expSat;
   } scoreEntry_t;

   scoreEntry_t scoreQ[$];
   int vectors     = 0;
   int miscompares = 0;

   always #5 port_clk = ~port_clk;

   dwc_error_handler dut (
      .port_clk           (port_clk),
      .port_rst_n         (port_rst_n),
      .port_valid         (port_valid),
      .port_dwc_error     (port_dwc_error),
      .port_clear         (port_clear),
      .port_retry         (port_retry),
      .port_hold          (port_hold),
      .port_syndrome      (port_syndrome),
      .port_transient_cnt (port_transient_cnt),
      .port_fault         (port_fault)
   );

   dwc_error_handler #(.CNT_W(2)) dutSat (
      .port_clk           (port_clk),
      .port_rst_n         (port_rst_n),
      .port_valid         (port_valid),
      .port_dwc_error     (port_dwc_error),
      .port_clear         (port_clear),
      .port_retry         (satRetry),
      .port_hold          (satHold),
      .port_syndrome      (satSyndrome),
      .port_transient_cnt (satTransientCnt),
      .port_fault         (satFault)
   );

   // Expected outputs for both instances; the narrow counter clamps at 3.
   task automatic pushExpected(input string tag, input logic r, input logic h,
                               input logic [3:0] s, input int c, input logic f);
      scoreEntry_t e;
      int satC;
      satC      = (c > 3) ? 3 : c;
      e.tag     = tag;
      e.expMain = {r, h, s, 8'(c), f};
      e.expSat  = {r, h, s, 2'(satC), f};
      scoreQ.push_back(e);
   endtask

   task automatic checkOutput();
      scoreEntry_t e;
      logic [14:0] obsMain;
      logic [8:0]  obsSat;
      if (scoreQ.size() == 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL scoreboard: observed empty queue, required an entry");
         return;
      end
      e       = scoreQ.pop_front();
      obsMain = {port_retry, port_hold, port_syndrome, port_transient_cnt, port_fault};
      obsSat  = {satRetry, satHold, satSyndrome, satTransientCnt, satFault};
      vectors++;
      assert (obsMain === e.expMain) else begin
         miscompares++;
         $error("[TB] FAIL %s main {retry,hold,syn,cnt,fault}: observed %b required %b", e.tag, obsMain, e.expMain);
      end
      vectors++;
      assert (obsSat === e.expSat) else begin
         miscompares++;
         $error("[TB] FAIL %s sat {retry,hold,syn,cnt,fault}: observed %b required %b", e.tag, obsSat, e.expSat);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic v, input logic [3:0] flags,
                                input logic clr, input logic r, input logic h,
                                input logic [3:0] s, input int c, input logic f);
      port_valid     = v;
      port_dwc_error = flags;
      port_clear     = clr;
      pushExpected(tag, r, h, s, c, f);
      @(posedge port_clk);
      #1;
      checkOutput();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no finish, required finish before 100000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      port_rst_n     = 1'b0;
      port_valid     = 1'b0;
      port_dwc_error = 4'b1111;
      port_clear     = 1'b0;
      #12;
      pushExpected("reset", 0, 0, 4'b0000, 0, 0);
      checkOutput();
      port_rst_n = 1'b1;

      // Clean traffic never disturbs the datapath.
      for (int i = 0; i < 20; i++)
         applyStimulus($sformatf("idle%0d", i), 1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);

      // Transient on unit 2: one retry, hold for six cycles, then recover.
      applyStimulus("tr_mis", 1, 4'b1011, 0, 1, 1, 4'b0100, 0, 0);
      for (int i = 1; i <= 5; i++)
         applyStimulus($sformatf("tr_wait%0d", i), 1, 4'b1111, 0, 0, 1, 4'b0100, 0, 0);
      applyStimulus("tr_done", 1, 4'b1111, 0, 0, 0, 4'b0100, 1, 0);
      applyStimulus("tr_idle", 1, 4'b1111, 0, 0, 0, 4'b0100, 1, 0);

      // Permanent fault on unit 0 after two retries, then software clear.
      applyStimulus("pf_preclr", 1, 4'b1111, 1, 0, 0, 4'b0000, 0, 0);
      applyStimulus("pf_mis", 1, 4'b1110, 0, 1, 1, 4'b0001, 0, 0);
      for (int i = 1; i <= 5; i++)
         applyStimulus($sformatf("pf_wait1_%0d", i), 1, 4'b1110, 0, 0, 1, 4'b0001, 0, 0);
      applyStimulus("pf_retry2", 1, 4'b1110, 0, 1, 1, 4'b0001, 0, 0);
      for (int i = 1; i <= 5; i++)
         applyStimulus($sformatf("pf_wait2_%0d", i), 1, 4'b1110, 0, 0, 1, 4'b0001, 0, 0);
      for (int i = 0; i < 4; i++)
         applyStimulus($sformatf("pf_fault%0d", i), 1, 4'b1110, 0, 0, 1, 4'b0001, 0, 1);
      applyStimulus("pf_clear", 1, 4'b1111, 1, 0, 0, 4'b0000, 0, 0);
      applyStimulus("pf_after", 1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);

      // Flags ignored while the timer runs, then invalid cycles stall in WAIT.
      applyStimulus("nv_mis", 1, 4'b0111, 0, 1, 1, 4'b1000, 0, 0);
      for (int i = 1; i <= 5; i++)
         applyStimulus($sformatf("nv_ignore%0d", i), 1, 4'b0000, 0, 0, 1, 4'b1000, 0, 0);
      for (int i = 0; i < 10; i++)
         applyStimulus($sformatf("nv_stall%0d", i), 0, 4'b0000, 0, 0, 1, 4'b1000, 0, 0);
      applyStimulus("nv_recover", 1, 4'b1111, 0, 0, 0, 4'b1000, 1, 0);

      // Clears during a retry sequence: no abort, new bits and recovery win.
      applyStimulus("cl_mis", 1, 4'b1101, 0, 1, 1, 4'b1010, 1, 0);
      applyStimulus("cl_inretry", 1, 4'b1111, 1, 0, 1, 4'b0000, 0, 0);
      for (int i = 1; i <= 4; i++)
         applyStimulus($sformatf("cl_wait1_%0d", i), 1, 4'b1111, 0, 0, 1, 4'b0000, 0, 0);
      applyStimulus("cl_evalmis", 1, 4'b1101, 1, 1, 1, 4'b0010, 0, 0);
      for (int i = 1; i <= 5; i++)
         applyStimulus($sformatf("cl_wait2_%0d", i), 1, 4'b1111, 0, 0, 1, 4'b0010, 0, 0);
      applyStimulus("cl_evalpass", 1, 4'b1111, 1, 0, 0, 4'b0000, 1, 0);

      // Five transient events: 8-bit counter 1..5, 2-bit counter 1,2,3,3,3.
      applyStimulus("sat_clr", 1, 4'b1111, 1, 0, 0, 4'b0000, 0, 0);
      for (int ev = 1; ev <= 5; ev++) begin
         applyStimulus($sformatf("sat%0d_mis", ev), 1, 4'b1011, 0, 1, 1, 4'b0100, ev - 1, 0);
         for (int i = 1; i <= 5; i++)
            applyStimulus($sformatf("sat%0d_wait%0d", ev, i), 1, 4'b1111, 0, 0, 1, 4'b0100, ev - 1, 0);
         applyStimulus($sformatf("sat%0d_done", ev), 1, 4'b1111, 0, 0, 0, 4'b0100, ev, 0);
      end

      // Asynchronous reset in the middle of WAIT.
      applyStimulus("rst_mis", 1, 4'b1011, 0, 1, 1, 4'b0100, 5, 0);
      applyStimulus("rst_wait1", 1, 4'b1111, 0, 0, 1, 4'b0100, 5, 0);
      applyStimulus("rst_wait2", 1, 4'b1111, 0, 0, 1, 4'b0100, 5, 0);
      #3;
      port_rst_n = 1'b0;
      #1;
      pushExpected("rst_async", 0, 0, 4'b0000, 0, 0);
      checkOutput();
      @(posedge port_clk);
      #1;
      pushExpected("rst_held", 0, 0, 4'b0000, 0, 0);
      checkOutput();
      #3;
      port_rst_n = 1'b1;
      applyStimulus("rst_idle", 1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);
      applyStimulus("rst_remis", 1, 4'b1011, 0, 1, 1, 4'b0100, 0, 0);
      applyStimulus("rst_rewait", 1, 4'b1111, 0, 0, 1, 4'b0100, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
